// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU bus-sequencing controller.
// Field offsets are helper functions so each instance derives them from its own WIDTH/RW.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSrc1,
        StOpb,
        StExec,
        StWb,
        StDone,
        StErr
    } state_e;

    localparam logic [2:0] FUNC_CMP = 3'b110;
    localparam logic [2:0] FUNC_ILL = 3'b111;

    // Layout from the MSB down: func[3], mode[1], dst[RW], src1[RW], low[L].
    function automatic int unsigned f_mode_bit(input int unsigned width);
        return width - 4;
    endfunction

    function automatic int unsigned f_dst_lsb(input int unsigned width, input int unsigned rw);
        return width - 4 - rw;
    endfunction

    function automatic int unsigned f_src1_lsb(input int unsigned width, input int unsigned rw);
        return width - 4 - 2 * rw;
    endfunction

    function automatic int unsigned f_low_width(input int unsigned width, input int unsigned rw);
        return width - 4 - 2 * rw;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_imm_ext.sv
// Extends the low instruction field to bus width, sign- or zero-filling per SIGN_EXT.
module imm_ext #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LW       = 8,
    parameter int unsigned SIGN_EXT = 0
) (
    input  logic [LW-1:0]    i_field,
    output logic [WIDTH-1:0] o_imm
);

    if (SIGN_EXT != 0) begin : g_sext
        assign o_imm = {{(WIDTH - LW){i_field[LW-1]}}, i_field};
    end else begin : g_zext
        assign o_imm = {{(WIDTH - LW){1'b0}}, i_field};
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Steps the shared bus through SRC1 -> OPB -> EXEC -> WB -> DONE for one ALU instruction.
// All outputs are Moore-decoded from the state and the latched instruction.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NREG     = 4,
    parameter int unsigned SIGN_EXT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_instr,
    output logic             o_busy,
    output logic [2:0]       o_alu_op,
    output logic             o_alu_in1,
    output logic             o_alu_in2,
    output logic             o_alu_outlatch,
    output logic             o_alu_out_en,
    output logic             o_imm_out,
    output logic [WIDTH-1:0] o_imm,
    output logic [NREG-1:0]  o_reg_in,
    output logic [NREG-1:0]  o_reg_out,
    output logic             o_pc_inc,
    output logic             o_done,
    output logic             o_err
);

    localparam int unsigned RW       = $clog2(NREG);
    localparam int unsigned LW       = f_low_width(WIDTH, RW);
    localparam int unsigned MODE_BIT = f_mode_bit(WIDTH);
    localparam int unsigned DST_LSB  = f_dst_lsb(WIDTH, RW);
    localparam int unsigned SRC1_LSB = f_src1_lsb(WIDTH, RW);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_instr;

    logic [2:0]       w_func;
    logic             w_mode;
    logic [RW-1:0]    w_dst;
    logic [RW-1:0]    w_src1;
    logic [RW-1:0]    w_src2;
    logic [LW-1:0]    w_low;
    logic [WIDTH-1:0] w_imm_ext;
    logic             w_accept;
    logic             w_start_ill;

    assign w_func      = r_instr[WIDTH-1 -: 3];
    assign w_mode      = r_instr[MODE_BIT];
    assign w_dst       = r_instr[DST_LSB +: RW];
    assign w_src1      = r_instr[SRC1_LSB +: RW];
    assign w_low       = r_instr[LW-1:0];
    assign w_src2      = w_low[RW-1:0];
    assign w_accept    = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_start_ill = (i_instr[WIDTH-1 -: 3] == FUNC_ILL);

    imm_ext #(
        .WIDTH    (WIDTH),
        .LW       (LW),
        .SIGN_EXT (SIGN_EXT)
    ) u_imm_ext (
        .i_field (w_low),
        .o_imm   (w_imm_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_instr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_instr <= i_instr;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_next_state = w_start_ill ? StErr : StSrc1;
                end else begin
                    w_next_state = StIdle;
                end
            end
            StSrc1:  w_next_state = StOpb;
            StOpb:   w_next_state = StExec;
            StExec:  w_next_state = (w_func == FUNC_CMP) ? StDone : StWb;
            StWb:    w_next_state = StDone;
            StErr:   w_next_state = StIdle;
            default: w_next_state = StIdle;
        endcase
    end

    always_comb begin
        o_busy         = (r_state != StIdle);
        o_alu_op       = o_busy ? w_func : 3'b000;
        o_alu_in1      = 1'b0;
        o_alu_in2      = 1'b0;
        o_alu_outlatch = 1'b0;
        o_alu_out_en   = 1'b0;
        o_imm_out      = 1'b0;
        o_imm          = '0;
        o_reg_in       = '0;
        o_reg_out      = '0;
        o_pc_inc       = 1'b0;
        o_done         = 1'b0;
        o_err          = 1'b0;

        // Immediate is only presented for a legal instruction in flight.
        if (w_mode && (r_state != StIdle) && (r_state != StErr)) begin
            o_imm = w_imm_ext;
        end

        unique case (r_state)
            StSrc1: begin
                o_reg_out[w_src1] = 1'b1;
                o_alu_in1         = 1'b1;
            end
            StOpb: begin
                o_alu_in2 = 1'b1;
                if (w_mode) begin
                    o_imm_out = 1'b1;
                end else begin
                    o_reg_out[w_src2] = 1'b1;
                end
            end
            StExec: o_alu_outlatch = 1'b1;
            StWb: begin
                o_alu_out_en     = 1'b1;
                o_reg_in[w_dst]  = 1'b1;
            end
            StDone: begin
                o_done   = 1'b1;
                o_pc_inc = 1'b1;
            end
            StErr: begin
                o_err    = 1'b1;
                o_pc_inc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed plus randomized bench for alu_seq_ctrl against a per-instruction schedule model.
module tb_alu_seq_ctrl;

    typedef struct packed {
        logic        busy;
        logic [2:0]  op;
        logic        in1;
        logic        in2;
        logic        olatch;
        logic        oen;
        logic        immo;
        logic [15:0] imm0;
        logic [15:0] imm1;
        logic [3:0]  rin;
        logic [3:0]  rout;
        logic        pc;
        logic        dn;
        logic        er;
        logic        last;
    } rec_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_instr = '0;

    logic        o_busy, o_alu_in1, o_alu_in2, o_alu_outlatch, o_alu_out_en, o_imm_out;
    logic [2:0]  o_alu_op;
    logic [15:0] o_imm;
    logic [3:0]  o_reg_in, o_reg_out;
    logic        o_pc_inc, o_done, o_err;

    logic        sx_busy, sx_alu_in1, sx_alu_in2, sx_alu_outlatch, sx_alu_out_en, sx_imm_out;
    logic [2:0]  sx_alu_op;
    logic [15:0] sx_imm;
    logic [3:0]  sx_reg_in, sx_reg_out;
    logic        sx_pc_inc, sx_done, sx_err;

    int unsigned total = 0;
    int unsigned bad = 0;
    rec_t        q[$];

    alu_seq_ctrl #(.WIDTH(16), .NREG(4), .SIGN_EXT(0)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_instr        (i_instr),
        .o_busy         (o_busy),
        .o_alu_op       (o_alu_op),
        .o_alu_in1      (o_alu_in1),
        .o_alu_in2      (o_alu_in2),
        .o_alu_outlatch (o_alu_outlatch),
        .o_alu_out_en   (o_alu_out_en),
        .o_imm_out      (o_imm_out),
        .o_imm          (o_imm),
        .o_reg_in       (o_reg_in),
        .o_reg_out      (o_reg_out),
        .o_pc_inc       (o_pc_inc),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    alu_seq_ctrl #(.WIDTH(16), .NREG(4), .SIGN_EXT(1)) dut_sx (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_instr        (i_instr),
        .o_busy         (sx_busy),
        .o_alu_op       (sx_alu_op),
        .o_alu_in1      (sx_alu_in1),
        .o_alu_in2      (sx_alu_in2),
        .o_alu_outlatch (sx_alu_outlatch),
        .o_alu_out_en   (sx_alu_out_en),
        .o_imm_out      (sx_imm_out),
        .o_imm          (sx_imm),
        .o_reg_in       (sx_reg_in),
        .o_reg_out      (sx_reg_out),
        .o_pc_inc       (sx_pc_inc),
        .o_done         (sx_done),
        .o_err          (sx_err)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Appends the cycle-by-cycle output schedule of one accepted instruction.
    task automatic push_instr(input logic [15:0] ins);
        logic [2:0] func;
        logic       mode;
        int         dst, src1, src2, low;
        rec_t       b, r;
        func = ins[15:13];
        mode = ins[12];
        dst  = (int'(ins) >> 10) % 4;
        src1 = (int'(ins) >> 8) % 4;
        low  = int'(ins) % 256;
        src2 = low % 4;
        b = '0;
        b.busy = 1'b1;
        b.op   = func;
        if (func == 3'd7) begin
            r = b; r.er = 1'b1; r.pc = 1'b1;
            q.push_back(r);
            return;
        end
        if (mode) begin
            b.imm0 = 16'(low);
            b.imm1 = (low >= 128) ? 16'(low + 65280) : 16'(low);
        end
        r = b; r.rout = 4'(1 << src1); r.in1 = 1'b1;
        q.push_back(r);
        r = b; r.in2 = 1'b1;
        if (mode) r.immo = 1'b1;
        else      r.rout = 4'(1 << src2);
        q.push_back(r);
        r = b; r.olatch = 1'b1;
        q.push_back(r);
        if (func != 3'd6) begin
            r = b; r.oen = 1'b1; r.rin = 4'(1 << dst);
            q.push_back(r);
        end
        r = b; r.dn = 1'b1; r.pc = 1'b1; r.last = 1'b1;
        q.push_back(r);
    endtask

    task automatic model_edge();
        logic acc;
        if (!i_rst_n) begin
            q.delete();
            return;
        end
        acc = i_start && ((q.size() == 0) || ((q.size() == 1) && q[0].last));
        if (q.size() != 0) void'(q.pop_front());
        if (acc) push_instr(i_instr);
    endtask

    task automatic check_all();
        rec_t e;
        e = (q.size() != 0) ? q[0] : '0;
        check("busy",     32'(o_busy),         32'(e.busy));
        check("alu_op",   32'(o_alu_op),       32'(e.op));
        check("alu_in1",  32'(o_alu_in1),      32'(e.in1));
        check("alu_in2",  32'(o_alu_in2),      32'(e.in2));
        check("outlatch", 32'(o_alu_outlatch), 32'(e.olatch));
        check("out_en",   32'(o_alu_out_en),   32'(e.oen));
        check("imm_out",  32'(o_imm_out),      32'(e.immo));
        check("imm_zext", 32'(o_imm),          32'(e.imm0));
        check("reg_in",   32'(o_reg_in),       32'(e.rin));
        check("reg_out",  32'(o_reg_out),      32'(e.rout));
        check("pc_inc",   32'(o_pc_inc),       32'(e.pc));
        check("done",     32'(o_done),         32'(e.dn));
        check("err",      32'(o_err),          32'(e.er));
        check("imm_sext", 32'(sx_imm),         32'(e.imm1));
        check("sx_done",  32'(sx_done),        32'(e.dn));
        check("sx_reg_in", 32'(sx_reg_in),     32'(e.rin));
    endtask

    task automatic cycle(input logic st, input logic [15:0] ins);
        i_start = st;
        i_instr = ins;
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'($urandom));
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        check_all();
        i_rst_n = 1'b1;

        // ADDI r0, r0, 2
        cycle(1'b1, 16'h1002);
        idle(6);
        // register form: dst 2, src1 1, src2 3
        cycle(1'b1, 16'h2903);
        idle(6);
        // CMP: no write-back
        cycle(1'b1, 16'hC600);
        idle(5);
        // illegal func
        cycle(1'b1, 16'hE000);
        idle(3);
        // immediate 8'hFF: zero- vs sign-extended
        cycle(1'b1, 16'h50FF);
        idle(6);

        // start held high: accepted only in IDLE/DONE
        for (int k = 0; k < 20; k++) cycle(1'b1, 16'($urandom));
        idle(6);

        // async reset during WB
        cycle(1'b1, 16'h2903);
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'($urandom));
        #2 i_rst_n = 1'b0;
        #1 q.delete();
        check_all();
        for (int k = 0; k < 2; k++) cycle(1'b0, 16'h0000);
        i_rst_n = 1'b1;
        cycle(1'b1, 16'h1002);
        idle(6);

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 2) == 0), 16'($urandom));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
